imem_loader: RTL and testbench

- Boot-time writer for the 128-word instruction memory.
- Accepts a byte stream over a valid/ready handshake (from a UART receiver or the testbench), packs 4 bytes per 32-bit word, and issues single-cycle word writes to the memory's write port.
- Holds the CPU out of fetch until the image is fully written.
- Write addresses are byte addresses. The memory indexes them with bits [8:2].

---
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Bundle of the byte-stream handshake, control/status and
//               instruction-memory write-port signals of imem_loader.
//               master : byte source / system side (drives start, in_byte,
//                        in_valid; observes everything else)
//               slave  : the loader itself
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    logic        start;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        cpu_hold;
    logic [7:0]  word_count;
    logic        error;

    modport master (
        output start, in_byte, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold,
               word_count, error
    );

    modport slave (
        input  start, in_byte, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold,
               word_count, error
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time writer for the instruction memory. Receives a
//               header byte N followed by 4*N data bytes over a valid/ready
//               handshake, packs 4 bytes per word and issues single-cycle
//               word writes. The CPU is held out of fetch until the image
//               is complete. N=0 or N>DEPTH loads DEPTH words.
// Ports       : clk      - system clock, rising edge
//               reset    - synchronous active-high reset
//               bus      - imem_loader_if.slave (stream in, memory write
//                          port, busy/done/cpu_hold/word_count/error)
// Options     : `define IMEM_LOADER_CHECKSUM_EN adds a trailing modulo-256
//               checksum byte; a mismatch flags error and keeps cpu_hold.
//               Without it, error is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH      = 128,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    imem_loader_if.slave  bus
);

    localparam int         c_idx_w = $clog2(DEPTH);
    localparam logic [7:0] c_depth = 8'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_busy;
    logic        r_done;
    logic        r_cpu_hold;
    logic [7:0]  r_word_count;
    logic [7:0]  r_target;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_asm;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        r_error;
    logic [7:0]  r_sum;
`endif

    logic        w_xfer;
    logic [7:0]  w_target;
    logic [31:0] w_asm_next;
    logic [7:0]  w_count_inc;

    assign w_xfer      = bus.in_valid && r_in_ready;
    assign w_count_inc = r_word_count + 8'd1;

    // Header decode: zero and oversize both mean a full-depth image.
    always_comb begin
        w_target = bus.in_byte;
        if (bus.in_byte == 8'd0 || bus.in_byte > c_depth) begin
            w_target = c_depth;
        end
    end

    // Word assembler: after four shifts the first byte sits in [31:24]
    // (big endian) or [7:0] (little endian).
    always_comb begin
        if (BIG_ENDIAN) begin
            w_asm_next = {r_asm[23:0], bus.in_byte};
        end else begin
            w_asm_next = {bus.in_byte, r_asm[31:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_word_count <= '0;
            r_target     <= '0;
            r_byte_cnt   <= '0;
            r_asm        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_error      <= 1'b0;
            r_sum        <= '0;
`endif
        end else begin
            case (r_state)
                // Start is only honoured when no load is running.
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state      <= S_HEADER;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_cpu_hold   <= 1'b1;
                        r_word_count <= '0;
                        r_byte_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_error      <= 1'b0;
                        r_sum        <= '0;
`endif
                    end
                end
                S_HEADER: begin
                    if (w_xfer) begin
                        r_target <= w_target;
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_asm      <= w_asm_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum      <= r_sum + bus.in_byte;
`endif
                        // Fourth byte: present the word next cycle and stall
                        // the stream for that one write cycle.
                        if (r_byte_cnt == 2'd3) begin
                            r_state    <= S_WRITE;
                            r_in_ready <= 1'b0;
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= {{(30 - c_idx_w){1'b0}},
                                           r_word_count[c_idx_w-1:0], 2'b00};
                            r_wr_data  <= w_asm_next;
                        end
                    end
                end
                S_WRITE: begin
                    r_wr_en      <= 1'b0;
                    r_word_count <= w_count_inc;
                    if (w_count_inc == r_target) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state    <= S_CHECK;
                        r_in_ready <= 1'b1;
`else
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_cpu_hold <= 1'b0;
`endif
                    end else begin
                        r_state    <= S_DATA;
                        r_in_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_xfer) begin
                        r_state    <= S_DONE;
                        r_in_ready <= 1'b0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        // A corrupt image is flagged but never released.
                        if (bus.in_byte == r_sum) begin
                            r_cpu_hold <= 1'b0;
                            r_error    <= 1'b0;
                        end else begin
                            r_error    <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_wr_en    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.word_count = r_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.error      = r_error;
`else
    assign bus.error      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Expected memory writes
//               are computed from the byte stream and queued when a load is
//               issued; a negedge monitor pops and compares on every wr_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset;

    imem_loader_if u_if ();

    imem_loader #(
        .DEPTH      (128),
        .BIG_ENDIAN (1'b1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [31:0] ea;
        logic [31:0] ed;
        if (reset === 1'b0 && u_if.wr_en === 1'b1) begin
            chk("wr_in_ready_low", {31'd0, u_if.in_ready}, 32'd0);
            if (exp_addr_q.size() == 0) begin
                chk("stray_wr_en", {31'd0, u_if.wr_en}, 32'd0);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                chk("wr_addr", u_if.wr_addr, ea);
                chk("wr_data", u_if.wr_data, ed);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},   {31'd0, u_if.in_ready}, 32'd0);
        chk({tag, "_wr_en"},      {31'd0, u_if.wr_en},    32'd0);
        chk({tag, "_busy"},       {31'd0, u_if.busy},     32'd0);
        chk({tag, "_done"},       {31'd0, u_if.done},     32'd0);
        chk({tag, "_error"},      {31'd0, u_if.error},    32'd0);
        chk({tag, "_wr_addr"},    u_if.wr_addr,           32'd0);
        chk({tag, "_wr_data"},    u_if.wr_data,           32'd0);
        chk({tag, "_word_count"}, {24'd0, u_if.word_count}, 32'd0);
        chk({tag, "_cpu_hold"},   {31'd0, u_if.cpu_hold}, 32'd1);
    endtask

    task automatic pulse_start();
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
    endtask

    // Offer one byte and hold it until the loader takes it. Returns #1 after
    // the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        u_if.in_byte  = b;
        u_if.in_valid = 1'b1;
        while (u_if.in_ready !== 1'b1) begin
            tick();
            t++;
            if (t > 50) begin
                chk("in_ready_timeout", {31'd0, u_if.in_ready}, 32'd1);
                break;
            end
        end
        tick();
        u_if.in_valid = 1'b0;
        u_if.in_byte  = 8'($urandom);
    endtask

    task automatic idle_cycles(input int gap);
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) tick();
    endtask

    // Full load: the reference model packs bytes big-endian with plain
    // arithmetic and queues (byte address, word) for every expected write.
    task automatic run_load(input logic [7:0] hdr, input logic [7:0] data_in[$],
                            input int gap, input bit bad_sum, input bit start_mid);
        logic [7:0]  d[$];
        logic [7:0]  sum;
        logic [31:0] w;
        int          n;
        int          t;
        bit          exp_err;

        n = (hdr == 8'd0 || hdr > 8'd128) ? 128 : int'(hdr);
        d = data_in;
        if (d.size() == 0) begin
            for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
        end
        sum = 8'd0;
        for (int i = 0; i < n; i++) begin
            w = 32'(d[4*i]) * 32'h0100_0000 + 32'(d[4*i+1]) * 32'h0001_0000
              + 32'(d[4*i+2]) * 32'h0000_0100 + 32'(d[4*i+3]);
            exp_addr_q.push_back(32'(i * 4));
            exp_data_q.push_back(w);
        end
        for (int i = 0; i < 4 * n; i++) sum = sum + d[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_err = bad_sum;
`else
        exp_err = 1'b0;
`endif

        pulse_start();
        chk("start_busy",     {31'd0, u_if.busy},     32'd1);
        chk("start_done",     {31'd0, u_if.done},     32'd0);
        chk("start_cpu_hold", {31'd0, u_if.cpu_hold}, 32'd1);
        chk("start_error",    {31'd0, u_if.error},    32'd0);
        chk("start_count",    {24'd0, u_if.word_count}, 32'd0);

        send_byte(hdr);
        idle_cycles(gap);
        for (int i = 0; i < 4 * n; i++) begin
            send_byte(d[i]);
            if (i % 4 == 3) chk("wr_latency", {31'd0, u_if.wr_en}, 32'd1);
            if (start_mid && i == 5) begin
                pulse_start();
                chk("mid_start_busy",  {31'd0, u_if.busy},       32'd1);
                chk("mid_start_count", {24'd0, u_if.word_count}, 32'd1);
                chk("mid_start_ready", {31'd0, u_if.in_ready},   32'd1);
            end
            idle_cycles(gap);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_sum ? sum + 8'd1 : sum);
`endif

        t = 0;
        while (u_if.done !== 1'b1) begin
            tick();
            t++;
            if (t > 100) begin
                chk("done_timeout", {31'd0, u_if.done}, 32'd1);
                break;
            end
        end
        chk("end_done",     {31'd0, u_if.done},       32'd1);
        chk("end_busy",     {31'd0, u_if.busy},       32'd0);
        chk("end_in_ready", {31'd0, u_if.in_ready},   32'd0);
        chk("end_count",    {24'd0, u_if.word_count}, 32'(n));
        chk("end_cpu_hold", {31'd0, u_if.cpu_hold},   {31'd0, exp_err});
        chk("end_error",    {31'd0, u_if.error},      {31'd0, exp_err});
        tick();
        chk("sb_drained",   32'(exp_addr_q.size()),   32'd0);
    endtask

    initial begin
        logic [7:0] two_word[$];
        logic [7:0] none_q[$];

        two_word = '{8'h34, 8'h04, 8'h00, 8'h00, 8'h34, 8'h05, 8'h01, 8'h00};

        reset         = 1'b1;
        u_if.start    = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_byte  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_vals("rst");

        // Input valid while idle must not handshake or write.
        u_if.in_valid = 1'b1;
        tick();
        chk("idle_in_ready", {31'd0, u_if.in_ready}, 32'd0);
        u_if.in_valid = 1'b0;

        run_load(8'd2, two_word, 0, 1'b0, 1'b0);
        run_load(8'd2, two_word, 3, 1'b0, 1'b0);
        run_load(8'd2, two_word, 0, 1'b1, 1'b0);
        run_load(8'd2, two_word, 0, 1'b0, 1'b0);
        run_load(8'd0, none_q, 0, 1'b0, 1'b0);
        run_load(8'd200, none_q, -1, 1'b0, 1'b0);

        // Reset mid-load after 6 data bytes (one word already written).
        exp_addr_q.push_back(32'h0);
        exp_data_q.push_back(32'h3404_0000);
        pulse_start();
        send_byte(8'd2);
        for (int i = 0; i < 6; i++) send_byte(two_word[i]);
        exp_addr_q.delete();
        exp_data_q.delete();
        u_if.in_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("midrst");
        repeat (10) tick();
        chk("midrst_no_ready", {31'd0, u_if.in_ready}, 32'd0);
        chk("midrst_count",    {24'd0, u_if.word_count}, 32'd0);
        u_if.in_valid = 1'b0;

        run_load(8'd2, none_q, 0, 1'b0, 1'b0);
        run_load(8'd5, none_q, -1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            run_load(8'($urandom_range(1, 24)), none_q, -1, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
